// File: rtl/voice_sequencer.sv
// Time-multiplexes VOICES voices onto one shared phase2sample ROM: snapshots inputs on CE,
// issues one ROM read per enabled voice, collects returned samples and publishes a whole frame.
module voice_sequencer #(
  parameter int unsigned VOICES = 8,
  parameter int unsigned LAT    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ce_i,
  input  logic [VOICES-1:0]     voice_en_i,
  input  logic [7*VOICES-1:0]   phase_i,
  input  logic [7*VOICES-1:0]   program_i,
  output logic [6:0]            p2s_phase_o,
  output logic [6:0]            p2s_program_o,
  output logic                  p2s_ce_o,
  input  logic [7:0]            p2s_sample_i,
  output logic [8*VOICES-1:0]   sample_o,
  output logic                  sample_valid_o,
  output logic                  busy_o,
  output logic                  overrun_o
);

  localparam int unsigned     IdxW     = $clog2(VOICES);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(VOICES - 1);
  localparam logic [1:0]      LastDrn  = 2'(LAT - 1);
  localparam logic [7:0]      MidScale = 8'd128;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [1:0]          drn_q, drn_d;
  logic                overrun_q, overrun_d;
  logic                accept;
  logic [VOICES-1:0]   en_q, en_d;
  logic [6:0]          phase_q [VOICES];
  logic [6:0]          phase_d [VOICES];
  logic [6:0]          prog_q [VOICES];
  logic [6:0]          prog_d [VOICES];
  logic [7:0]          shadow_q [VOICES];
  logic [7:0]          shadow_d [VOICES];
  logic [8*VOICES-1:0] sample_q;
  logic                p2s_ce_q, p2s_ce_d;
  logic [6:0]          p2s_phase_q, p2s_phase_d;
  logic [6:0]          p2s_prog_q, p2s_prog_d;

  // Issue tags travel alongside the ROM latency so each return lands in its own slot.
  logic                cap_vld_q [LAT];
  logic                cap_en_q [LAT];
  logic [IdxW-1:0]     cap_idx_q [LAT];

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    drn_d     = drn_q;
    overrun_d = overrun_q;
    en_d      = en_q;
    phase_d   = phase_q;
    prog_d    = prog_q;
    accept    = 1'b0;

    unique case (state_q)
      StIdle: accept = ce_i;
      StIssue: begin
        overrun_d = overrun_q | ce_i;
        if (idx_q == LastIdx) begin
          state_d = StDrain;
          drn_d   = 2'd0;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDrain: begin
        overrun_d = overrun_q | ce_i;
        if (drn_q == LastDrn) state_d = StDone;
        else                  drn_d   = drn_q + 2'd1;
      end
      StDone: begin
        state_d = StIdle;
        accept  = ce_i;
      end
      default: state_d = StIdle;
    endcase

    if (accept) begin
      state_d = StIssue;
      idx_d   = '0;
      en_d    = voice_en_i;
      for (int i = 0; i < int'(VOICES); i++) begin
        phase_d[i] = phase_i[7*i +: 7];
        prog_d[i]  = program_i[7*i +: 7];
      end
    end

    // Outputs are registered, so they are computed from the next-cycle state and voice.
    p2s_ce_d    = (state_d == StIssue) && en_d[idx_d];
    p2s_phase_d = p2s_ce_d ? phase_d[idx_d] : 7'd0;
    p2s_prog_d  = p2s_ce_d ? prog_d[idx_d]  : 7'd0;

    shadow_d = shadow_q;
    if (cap_vld_q[LAT-1]) begin
      shadow_d[cap_idx_q[LAT-1]] = cap_en_q[LAT-1] ? p2s_sample_i : MidScale;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      drn_q       <= 2'd0;
      overrun_q   <= 1'b0;
      en_q        <= '0;
      p2s_ce_q    <= 1'b0;
      p2s_phase_q <= 7'd0;
      p2s_prog_q  <= 7'd0;
      for (int i = 0; i < int'(VOICES); i++) begin
        phase_q[i]         <= 7'd0;
        prog_q[i]          <= 7'd0;
        shadow_q[i]        <= MidScale;
        sample_q[8*i +: 8] <= MidScale;
      end
      for (int s = 0; s < int'(LAT); s++) begin
        cap_vld_q[s] <= 1'b0;
        cap_en_q[s]  <= 1'b0;
        cap_idx_q[s] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      drn_q       <= drn_d;
      overrun_q   <= overrun_d;
      en_q        <= en_d;
      phase_q     <= phase_d;
      prog_q      <= prog_d;
      shadow_q    <= shadow_d;
      p2s_ce_q    <= p2s_ce_d;
      p2s_phase_q <= p2s_phase_d;
      p2s_prog_q  <= p2s_prog_d;
      cap_vld_q[0] <= (state_q == StIssue);
      cap_en_q[0]  <= en_q[idx_q];
      cap_idx_q[0] <= idx_q;
      for (int s = 1; s < int'(LAT); s++) begin
        cap_vld_q[s] <= cap_vld_q[s-1];
        cap_en_q[s]  <= cap_en_q[s-1];
        cap_idx_q[s] <= cap_idx_q[s-1];
      end
      // The final capture coincides with entry to DONE, so publish the merged shadow set.
      if (state_d == StDone) begin
        for (int i = 0; i < int'(VOICES); i++) sample_q[8*i +: 8] <= shadow_d[i];
      end
    end
  end

  assign p2s_ce_o       = p2s_ce_q;
  assign p2s_phase_o    = p2s_phase_q;
  assign p2s_program_o  = p2s_prog_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = (state_q == StDone);
  assign busy_o         = (state_q == StIssue) || (state_q == StDrain);
  assign overrun_o      = overrun_q;

endmodule

// File: tb/tb_voice_sequencer.sv
// Directed bench for voice_sequencer: LAT=1 and LAT=3 instances, each fed by a delayed ROM model.
module tb_voice_sequencer;

  logic        clk;
  logic        rst;
  logic        ce;
  logic        sel3;
  logic [7:0]  voice_en;
  logic [55:0] phase_in;
  logic [55:0] prog_in;

  logic        ce1, ce3;
  logic [6:0]  ph1, pg1, ph3, pg3;
  logic        p2s_ce1, p2s_ce3;
  logic [7:0]  rom1, r3a, r3b, r3c;
  logic [63:0] smp1, smp3;
  logic        vld1, vld3, busy1, busy3, ovr1, ovr3;

  logic        s_p2s_ce, s_vld, s_busy;
  logic [6:0]  s_ph, s_pg;
  logic [63:0] s_smp;

  int          checks;
  int          failures;
  int          nvalid;
  logic [63:0] last_exp;

  localparam logic [63:0] AllMid = {8{8'd128}};

  assign ce1 = ce & ~sel3;
  assign ce3 = ce & sel3;

  voice_sequencer #(.VOICES(8), .LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce1), .voice_en_i(voice_en), .phase_i(phase_in),
    .program_i(prog_in), .p2s_phase_o(ph1), .p2s_program_o(pg1), .p2s_ce_o(p2s_ce1),
    .p2s_sample_i(rom1), .sample_o(smp1), .sample_valid_o(vld1), .busy_o(busy1),
    .overrun_o(ovr1)
  );

  voice_sequencer #(.VOICES(8), .LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce3), .voice_en_i(voice_en), .phase_i(phase_in),
    .program_i(prog_in), .p2s_phase_o(ph3), .p2s_program_o(pg3), .p2s_ce_o(p2s_ce3),
    .p2s_sample_i(r3c), .sample_o(smp3), .sample_valid_o(vld3), .busy_o(busy3),
    .overrun_o(ovr3)
  );

  assign s_p2s_ce = sel3 ? p2s_ce3 : p2s_ce1;
  assign s_ph     = sel3 ? ph3 : ph1;
  assign s_pg     = sel3 ? pg3 : pg1;
  assign s_vld    = sel3 ? vld3 : vld1;
  assign s_busy   = sel3 ? busy3 : busy1;
  assign s_smp    = sel3 ? smp3 : smp1;

  function automatic logic [7:0] rom_f(input logic [6:0] ph, input logic [6:0] pg);
    return ({ph, 1'b0} + 8'd7) ^ {1'b0, pg};
  endfunction

  // ROM models; 8'hEE marks a cycle with no read so stray captures are visible.
  always @(posedge clk) begin
    rom1 <= p2s_ce1 ? rom_f(ph1, pg1) : 8'hEE;
    r3a  <= p2s_ce3 ? rom_f(ph3, pg3) : 8'hEE;
    r3b  <= r3a;
    r3c  <= r3b;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts a frame on the current negedge and checks every cycle up to and including DONE.
  task automatic run_frame(input string tag, input logic [7:0] en, input logic [6:0] pbase,
                           input logic [6:0] gmul, input int ovr_at);
    int          lat;
    logic [6:0]  ph [8];
    logic [6:0]  pg [8];
    logic [63:0] exp_s;
    lat = sel3 ? 3 : 1;
    voice_en = en;
    for (int i = 0; i < 8; i++) begin
      ph[i] = pbase + 7'(i);
      pg[i] = gmul * 7'(i);
      phase_in[7*i +: 7] = ph[i];
      prog_in[7*i +: 7]  = pg[i];
      exp_s[8*i +: 8]    = en[i] ? rom_f(ph[i], pg[i]) : 8'd128;
    end
    ce = 1'b1;
    for (int j = 1; j <= 9 + lat; j++) begin
      @(negedge clk);
      ce = (j == ovr_at);
      if (j == ovr_at) begin
        phase_in = ~phase_in;
        voice_en = ~voice_en;
      end
      if (j <= 8) begin
        chk({tag, ":issue_ce"}, 64'(s_p2s_ce), 64'(en[j-1]));
        chk({tag, ":issue_phase"}, 64'(s_ph), en[j-1] ? 64'(ph[j-1]) : 64'd0);
        chk({tag, ":issue_prog"}, 64'(s_pg), en[j-1] ? 64'(pg[j-1]) : 64'd0);
        chk({tag, ":issue_busy"}, 64'(s_busy), 64'd1);
        chk({tag, ":issue_valid"}, 64'(s_vld), 64'd0);
      end else if (j <= 8 + lat) begin
        chk({tag, ":drain_ce"}, 64'(s_p2s_ce), 64'd0);
        chk({tag, ":drain_phase"}, 64'(s_ph), 64'd0);
        chk({tag, ":drain_busy"}, 64'(s_busy), 64'd1);
        chk({tag, ":drain_valid"}, 64'(s_vld), 64'd0);
      end else begin
        chk({tag, ":done_valid"}, 64'(s_vld), 64'd1);
        chk({tag, ":done_busy"}, 64'(s_busy), 64'd0);
        chk({tag, ":done_samples"}, s_smp, exp_s);
      end
    end
    last_exp = exp_s;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    sel3 = 1'b0;
    rst = 1'b1;
    ce = 1'b0;
    voice_en = 8'hFF;
    phase_in = '0;
    prog_in = '0;

    // Reset state, with CE held high alongside RST.
    repeat (2) @(negedge clk);
    ce = 1'b1;
    @(negedge clk);
    chk("rst:busy", 64'(busy1), 64'd0);
    chk("rst:valid", 64'(vld1), 64'd0);
    chk("rst:overrun", 64'(ovr1), 64'd0);
    chk("rst:p2s_ce", 64'(p2s_ce1), 64'd0);
    chk("rst:phase", 64'(ph1), 64'd0);
    chk("rst:program", 64'(pg1), 64'd0);
    chk("rst:samples", smp1, AllMid);
    chk("rst:samples3", smp3, AllMid);
    rst = 1'b0;
    ce = 1'b0;
    @(negedge clk);
    chk("rst:ce_ignored", 64'(busy1), 64'd0);

    // All voices enabled, phase i = i, program 0.
    run_frame("A", 8'hFF, 7'd0, 7'd0, 0);
    @(negedge clk);
    chk("A:valid_pulse", 64'(vld1), 64'd0);
    chk("A:hold", smp1, last_exp);

    // Sparse enables, then a CE in the DONE cycle for a back-to-back frame.
    run_frame("B", 8'hA5, 7'd10, 7'd3, 0);
    run_frame("C", 8'h3C, 7'd40, 7'd5, 0);
    chk("C:no_overrun", 64'(ovr1), 64'd0);

    // CE four cycles into a frame is ignored but flagged.
    @(negedge clk);
    run_frame("D", 8'hFF, 7'd90, 7'd1, 4);
    chk("D:overrun", 64'(ovr1), 64'd1);
    repeat (3) @(negedge clk);
    chk("D:overrun_sticky", 64'(ovr1), 64'd1);
    chk("D:idle_busy", 64'(busy1), 64'd0);

    // RST in issue cycle 3 aborts the frame.
    voice_en = 8'hFF;
    ce = 1'b1;
    @(negedge clk);
    ce = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("R:busy", 64'(busy1), 64'd0);
    chk("R:samples", smp1, AllMid);
    chk("R:overrun_clr", 64'(ovr1), 64'd0);
    chk("R:p2s_ce", 64'(p2s_ce1), 64'd0);
    nvalid = 0;
    repeat (12) begin
      @(negedge clk);
      if (vld1) nvalid++;
    end
    chk("R:no_valid", 64'(nvalid), 64'd0);
    run_frame("E", 8'h5A, 7'd20, 7'd9, 0);

    // LAT=3 instance.
    @(negedge clk);
    sel3 = 1'b1;
    @(negedge clk);
    run_frame("L3a", 8'hFF, 7'd60, 7'd2, 0);
    run_frame("L3b", 8'h81, 7'd33, 7'd7, 0);
    chk("L3:overrun", 64'(ovr3), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_sequencer.md
VOICE_SEQUENCER -- requirements
Module: voice_sequencer

Interface
REQ-001 Parameter VOICES, default 8, is the number of voices time-multiplexed onto one phase2sample instance; legal range is 2..16.
REQ-002 Parameter LAT, default 1, is the phase2sample read latency in CLK cycles from a P2S_CE-qualified address to a valid P2S_SAMPLE; legal range is 1..3.
REQ-003 CLK  in  1  single system clock; all state changes on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 CE  in  1  sample-rate strobe, one CLK wide; starts one frame.
REQ-006 VOICE_EN  in  VOICES  per-voice enable; bit i enables voice i.
REQ-007 PHASE_IN  in  7*VOICES  packed voice phases; voice i is bits [7i+6:7i].
REQ-008 PROGRAM_IN  in  7*VOICES  packed voice programs; voice i is bits [7i+6:7i].
REQ-009 P2S_PHASE  out  7  phase to the shared phase2sample.
REQ-010 P2S_PROGRAM  out  7  program to the shared phase2sample.
REQ-011 P2S_CE  out  1  read enable to the shared phase2sample.
REQ-012 P2S_SAMPLE  in  8  sample returned by the shared phase2sample.
REQ-013 SAMPLE_OUT  out  8*VOICES  packed per-voice samples; voice i is bits [8i+7:8i].
REQ-014 SAMPLE_VALID  out  1  one-cycle pulse; SAMPLE_OUT holds a new complete frame.
REQ-015 BUSY  out  1  a frame is in progress.
REQ-016 OVERRUN  out  1  sticky flag; a CE arrived while BUSY was high.

Function
REQ-017 States SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-018 In IDLE, CE=1 SHALL snapshot VOICE_EN, PHASE_IN and PROGRAM_IN into internal registers and move to ISSUE on the same edge.
- Inputs SHALL be ignored after the snapshot until the next accepted CE.
REQ-019 ISSUE SHALL last exactly VOICES cycles; cycle k (k=0..VOICES-1) SHALL present snapshot voice k on registered P2S_PHASE and P2S_PROGRAM.
- P2S_CE=1 in cycle k only if snapshot enable bit k=1.
REQ-020 The sample for voice k SHALL be captured from P2S_SAMPLE exactly LAT cycles after its issue cycle, into an internal shadow register for slot k.
REQ-021 A disabled voice SHALL be given shadow value 8'd128 (midscale) and SHALL NOT generate a ROM access.
REQ-022 DRAIN SHALL last exactly LAT cycles so that the last capture completes; P2S_CE=0 throughout DRAIN.
REQ-023 In DONE (one cycle), all shadow registers SHALL be copied to SAMPLE_OUT atomically, SAMPLE_VALID=1 and BUSY=0; the next state is IDLE.
REQ-024 SAMPLE_OUT SHALL change only in DONE; outside DONE it holds the previous frame.
REQ-025 The accepting CE edge to the SAMPLE_VALID cycle SHALL be VOICES+LAT+1 cycles (10 for the defaults).
REQ-026 BUSY SHALL be 1 in ISSUE and DRAIN and 0 in IDLE and DONE.
REQ-027 CE=1 while BUSY=1 SHALL be ignored and SHALL set OVERRUN=1; OVERRUN clears only on RST.
REQ-028 CE=1 in the DONE cycle SHALL be accepted as a new frame, with the snapshot taken on that edge, so frames run back to back without a gap.
REQ-029 P2S_PHASE and P2S_PROGRAM SHALL be 0 whenever P2S_CE=0 outside ISSUE.
REQ-030 The voice index counter SHALL be ceil(log2(VOICES)) bits wide and SHALL NOT wrap within a frame.

Reset
REQ-031 While RST=1, the state SHALL be IDLE, BUSY=0, SAMPLE_VALID=0, OVERRUN=0, P2S_CE=0, P2S_PHASE=0 and P2S_PROGRAM=0.
REQ-032 While RST=1, SAMPLE_OUT and all shadow registers SHALL be 8'd128 per voice.
REQ-033 RST asserted mid-frame SHALL abort the frame with no SAMPLE_VALID pulse; CE coincident with RST is ignored.

Verification
REQ-034 VOICES=8, LAT=1, all enabled, voice i phase=i, program=0, CE once -> P2S_CE high for 8 cycles with P2S_PHASE 0..7; SAMPLE_VALID exactly 10 cycles after CE; each slot equals the model's phase2sample output.
REQ-035 VOICE_EN=8'b1010_0101 -> P2S_CE only in issue cycles 0, 2, 5 and 7; slots 1, 3, 4 and 6 = 128.
REQ-036 CE again 4 cycles after an accepted CE -> ignored; OVERRUN=1 and stays 1; frame timing unchanged.
REQ-037 CE in the DONE cycle -> new frame starts; next SAMPLE_VALID exactly 10 cycles later; OVERRUN=0.
REQ-038 RST pulse in ISSUE cycle 3 -> BUSY=0 next cycle, no SAMPLE_VALID, SAMPLE_OUT all 128; the next CE runs a normal frame.
REQ-039 LAT=3 with a 3-stage delayed ROM model -> SAMPLE_VALID 12 cycles after CE; slots correctly aligned (no off-by-one voice).
